apb_regbank_slave: RTL and testbench

- APB4 completer: the responder end of one APB output port of the AXI-to-APB bridge.
- Holds a bank of NUM_REGS software-visible registers and decodes word-aligned addresses.
- Inserts a programmable number of wait states and flags protocol/address errors through PSLVERR.
- Exposes register contents and per-register write pulses to local hardware, plus a hardware update port.

---
 rtl/apb_regbank_pkg.sv | 20 ++
 rtl/apb_regbank_decode.sv | 49 ++++
 rtl/apb_regbank_slave.sv | 152 +++++++++++++++
 tb/tb_apb_regbank_slave.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_regbank_pkg.sv
// Shared types for the APB register bank: FSM states, decode error causes, address-to-index helper.
package apb_regbank_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS
   } state_t;

   localparam logic [2:0] ERR_NONE  = 3'd0;
   localparam logic [2:0] ERR_RANGE = 3'd1;
   localparam logic [2:0] ERR_ALIGN = 3'd2;
   localparam logic [2:0] ERR_RO    = 3'd3;
   localparam logic [2:0] ERR_PROT  = 3'd4;

   function automatic logic [63:0] addr_to_idx(input logic [63:0] offset, input int unsigned lane_bits);
      return offset >> lane_bits;
   endfunction

endpackage

// File: rtl/apb_regbank_decode.sv
// Combinational PADDR/PWRITE/PPROT decoder producing a register index and an error cause.
// Latency 0; no flow control. APB_PPROT_CHECK_EN rejects unprivileged writes.
module apb_regbank_decode
   import apb_regbank_pkg::*;
#(
   parameter int                         APB_addr_length = 32,
   parameter int                         APB_strb_length = 2,
   parameter int                         NUM_REGS        = 8,
   parameter logic [APB_addr_length-1:0] BASE_ADDR       = 32'h0000_1000,
   parameter int                         IDX_W           = $clog2(NUM_REGS)
) (
   input  logic [APB_addr_length-1:0] paddr,
   input  logic                       pwrite,
   input  logic [2:0]                 pprot,
   output logic [IDX_W-1:0]           idx,
   output logic [2:0]                 err_cause
);

   localparam int LANE_BITS = $clog2(APB_strb_length);
   localparam logic [APB_addr_length-1:0] ALIGN_MASK =
      APB_addr_length'((64'd1 << LANE_BITS) - 64'd1);

   logic [APB_addr_length-1:0] offset;
   logic [63:0]                word_idx;

   always_comb begin
      offset    = paddr - BASE_ADDR;
      word_idx  = addr_to_idx(64'(offset), LANE_BITS);
      idx       = word_idx[IDX_W-1:0];
      err_cause = ERR_NONE;
      // Range is checked on the full-width index so aliasing high bits cannot wrap into the bank.
      if (paddr < BASE_ADDR || word_idx >= 64'(NUM_REGS))
         err_cause = ERR_RANGE;
      else if ((offset & ALIGN_MASK) != '0)
         err_cause = ERR_ALIGN;
      else if (pwrite && word_idx == 64'd0)
         err_cause = ERR_RO;
`ifdef APB_PPROT_CHECK_EN
      else if (pwrite && !pprot[0])
         err_cause = ERR_PROT;
`endif
   end

`ifndef APB_PPROT_CHECK_EN
   logic unused_pprot;
   assign unused_pprot = ^pprot;
`endif

endmodule

// File: rtl/apb_regbank_slave.sv
// APB4 completer with NUM_REGS registers, ID at index 0, hardware update port; APB_PPROT_CHECK_EN enables PPROT write check.
// Completion on access cycle WAIT_STATES+1 (PREADY low before); register update and wr_pulse one cycle after PREADY.
module apb_regbank_slave
   import apb_regbank_pkg::*;
#(
   parameter int                         APB_addr_length = 32,
   parameter int                         APB_data_length = 16,
   parameter int                         APB_strb_length = 2,
   parameter int                         NUM_REGS        = 8,
   parameter logic [APB_addr_length-1:0] BASE_ADDR       = 32'h0000_1000,
   parameter int                         WAIT_STATES     = 1,
   parameter logic [APB_data_length-1:0] ID_VALUE        = 16'hA5B0
) (
   input  logic                                PCLK,
   input  logic                                PRESETn,
   input  logic [APB_addr_length-1:0]          PADDR,
   input  logic [2:0]                          PPROT,
   input  logic [APB_strb_length-1:0]          PSTRB,
   input  logic                                PSEL,
   input  logic                                PENABLE,
   input  logic                                PWRITE,
   input  logic [APB_data_length-1:0]          PWDATA,
   output logic [APB_data_length-1:0]          PRDATA,
   output logic                                PREADY,
   output logic                                PSLVERR,
   input  logic                                hw_we,
   input  logic [$clog2(NUM_REGS)-1:0]         hw_idx,
   input  logic [APB_data_length-1:0]          hw_wdata,
   output logic [NUM_REGS*APB_data_length-1:0] reg_q,
   output logic [NUM_REGS-1:0]                 wr_pulse
);

   localparam int         IDX_W = $clog2(NUM_REGS);
   localparam int         DW    = APB_data_length;
   localparam logic [3:0] WS    = 4'(WAIT_STATES);

   typedef struct packed {
      logic             wr;
      logic [2:0]       err;
      logic [IDX_W-1:0] idx;
   } xfer_t;

   state_t           state, state_nxt;
   logic [3:0]       wait_cnt, wait_cnt_nxt;
   xfer_t            xfer;
   logic [IDX_W-1:0] dec_idx;
   logic [2:0]       dec_err;
   logic             setup_seen, access_seen, done, wr_fire;
   logic [DW-1:0]    regs [NUM_REGS];
   logic [DW-1:0]    apb_merged;

   assign setup_seen  = PSEL && !PENABLE;
   assign access_seen = PSEL && PENABLE;

   apb_regbank_decode #(
      .APB_addr_length(APB_addr_length),
      .APB_strb_length(APB_strb_length),
      .NUM_REGS       (NUM_REGS),
      .BASE_ADDR      (BASE_ADDR),
      .IDX_W          (IDX_W)
   ) u_decode (
      .paddr    (PADDR),
      .pwrite   (PWRITE),
      .pprot    (PPROT),
      .idx      (dec_idx),
      .err_cause(dec_err)
   );

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state    <= IDLE;
         wait_cnt <= '0;
         xfer     <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
         if (setup_seen)
            xfer <= '{wr: PWRITE, err: dec_err, idx: dec_idx};
      end
   end

   // SETUP is the first access cycle; wait_cnt counts access cycles already spent before ACCESS.
   always_comb begin
      state_nxt    = IDLE;
      wait_cnt_nxt = '0;
      if (setup_seen) begin
         state_nxt = SETUP;
      end else if (access_seen && !done) begin
         case (state)
            SETUP: begin
               state_nxt    = ACCESS;
               wait_cnt_nxt = 4'd1;
            end
            ACCESS: begin
               state_nxt    = ACCESS;
               wait_cnt_nxt = (wait_cnt < WS) ? wait_cnt + 4'd1 : wait_cnt;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      done = 1'b0;
      if (access_seen) begin
         case (state)
            SETUP:   done = (WS == 4'd0);
            ACCESS:  done = (wait_cnt == WS);
            default: done = 1'b0;
         endcase
      end
      PREADY  = done;
      PSLVERR = done && (xfer.err != ERR_NONE);
      wr_fire = done && xfer.wr && (xfer.err == ERR_NONE);
      PRDATA  = '0;
      if (done && !xfer.wr && xfer.err == ERR_NONE)
         PRDATA = (xfer.idx == '0) ? ID_VALUE : regs[xfer.idx];
   end

   always_comb begin
      apb_merged = regs[xfer.idx];
      for (int b = 0; b < APB_strb_length; b++)
         if (PSTRB[b])
            apb_merged[b*8 +: 8] = PWDATA[b*8 +: 8];
   end

   // Index 0 is the read-only ID slot, so neither port ever writes its storage.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         for (int i = 0; i < NUM_REGS; i++)
            regs[i] <= '0;
         wr_pulse <= '0;
      end else begin
         wr_pulse <= '0;
         for (int i = 1; i < NUM_REGS; i++) begin
            if (wr_fire && xfer.idx == IDX_W'(i)) begin
               regs[i]     <= apb_merged;
               wr_pulse[i] <= 1'b1;
            end else if (hw_we && hw_idx == IDX_W'(i)) begin
               regs[i] <= hw_wdata;
            end
         end
      end
   end

   always_comb begin
      reg_q = '0;
      for (int i = 0; i < NUM_REGS; i++)
         reg_q[i*DW +: DW] = regs[i];
   end

endmodule

// File: tb/tb_apb_regbank_slave.sv
// Randomized and directed bench for apb_regbank_slave against a register-array reference model.
module tb_apb_regbank_slave;

   localparam int          AW   = 32;
   localparam int          DW   = 16;
   localparam int          SW   = 2;
   localparam int          NR   = 8;
   localparam int          WS   = 1;
   localparam logic [31:0] BASE = 32'h0000_1000;
   localparam logic [15:0] IDV  = 16'hA5B0;

   logic           PCLK = 1'b0;
   logic           PRESETn = 1'b0;
   logic [AW-1:0]  PADDR = '0;
   logic [2:0]     PPROT = '0;
   logic [SW-1:0]  PSTRB = '0;
   logic           PSEL = 1'b0;
   logic           PENABLE = 1'b0;
   logic           PWRITE = 1'b0;
   logic [DW-1:0]  PWDATA = '0;
   logic [DW-1:0]  PRDATA;
   logic           PREADY;
   logic           PSLVERR;
   logic           hw_we = 1'b0;
   logic [2:0]     hw_idx = '0;
   logic [DW-1:0]  hw_wdata = '0;
   logic [NR*DW-1:0] reg_q;
   logic [NR-1:0]  wr_pulse;

   int checks = 0;
   int errors = 0;
   logic [DW-1:0] mdl [NR];

   always #5 PCLK = ~PCLK;

   apb_regbank_slave #(
      .APB_addr_length(AW), .APB_data_length(DW), .APB_strb_length(SW),
      .NUM_REGS(NR), .BASE_ADDR(BASE), .WAIT_STATES(WS), .ID_VALUE(IDV)
   ) dut (
      .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(PADDR), .PPROT(PPROT), .PSTRB(PSTRB),
      .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
      .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
      .hw_we(hw_we), .hw_idx(hw_idx), .hw_wdata(hw_wdata),
      .reg_q(reg_q), .wr_pulse(wr_pulse)
   );

   // Reference decode straight from the address map rules.
   function automatic logic exp_err(input logic [31:0] addr, input logic wr, input logic [2:0] prot, output int idx);
      longint off;
      idx = 0;
      if (addr < BASE) return 1'b1;
      off = longint'(addr) - longint'(BASE);
      if (off % SW != 0) return 1'b1;
      if (off / SW >= NR) return 1'b1;
      idx = int'(off / SW);
      if (wr && idx == 0) return 1'b1;
`ifdef APB_PPROT_CHECK_EN
      if (wr && !prot[0]) return 1'b1;
`endif
      return 1'b0;
   endfunction

   function automatic void mdl_apply(input logic [31:0] addr, input logic wr, input logic [15:0] wd,
                                     input logic [1:0] strb, input logic [2:0] prot, input logic hw_en,
                                     input logic [2:0] hw_i, input logic [15:0] hw_d,
                                     output logic e, output logic [15:0] rd, output logic [NR-1:0] pulse);
      int idx;
      e = exp_err(addr, wr, prot, idx);
      rd = '0;
      pulse = '0;
      if (!e && !wr) rd = (idx == 0) ? IDV : mdl[idx];
      if (hw_en && hw_i != 3'd0) mdl[hw_i] = hw_d;
      if (!e && wr) begin
         for (int b = 0; b < SW; b++)
            if (strb[b]) mdl[idx][b*8 +: 8] = wd[b*8 +: 8];
         pulse[idx] = 1'b1;
      end
   endfunction

   function automatic logic [NR*DW-1:0] mdl_flat();
      logic [NR*DW-1:0] f;
      f = '0;
      for (int i = 1; i < NR; i++) f[i*DW +: DW] = mdl[i];
      return f;
   endfunction

   function automatic void mdl_clear();
      for (int i = 0; i < NR; i++) mdl[i] = '0;
   endfunction

   // One APB transfer; entered just after a rising edge, leaves just after the edge following PREADY.
   task automatic apb_xfer(input logic [31:0] addr, input logic wr, input logic [15:0] wd, input logic [1:0] strb,
                           input logic [2:0] prot, input logic hw_en, input logic [2:0] hw_i, input logic [15:0] hw_d,
                           output int n, output logic [15:0] rd, output logic err,
                           output logic [NR*DW-1:0] q1, output logic [NR-1:0] p1);
      PSEL = 1'b1; PENABLE = 1'b0; PADDR = addr; PWRITE = wr; PWDATA = wd; PSTRB = strb; PPROT = prot;
      @(posedge PCLK) #1;
      PENABLE = 1'b1;
      n = 1;
      forever begin
         @(negedge PCLK);
         if (PREADY) break;
         if (n >= 40) begin
            checks++; errors++;
            $display("FAIL ready_timeout got no PREADY after %0d access cycles want PREADY", n);
            break;
         end
         @(posedge PCLK) #1;
         n++;
      end
      rd = PRDATA; err = PSLVERR;
      hw_we = hw_en; hw_idx = hw_i; hw_wdata = hw_d;
      @(posedge PCLK) #1;
      hw_we = 1'b0;
      q1 = reg_q; p1 = wr_pulse;
      PSEL = 1'b0; PENABLE = 1'b0;
   endtask

   task automatic test_reset();
      int n; logic [15:0] rd; logic e, xe; logic [15:0] xrd; logic [NR-1:0] p1, xp;
      logic [NR*DW-1:0] q1; logic seen;
      PRESETn = 1'b0;
      repeat (2) @(posedge PCLK);
      #1;
      checks++;
      if ({PREADY, PSLVERR, PRDATA, wr_pulse, reg_q} !== '0) begin
         errors++; $display("FAIL reset_state got rdy=%b err=%b rd=%h p=%b q=%h want all 0", PREADY, PSLVERR, PRDATA, wr_pulse, reg_q);
      end
      PRESETn = 1'b1;
      mdl_clear();
      @(posedge PCLK) #1;
      mdl_apply(32'h1008, 1, 16'h1234, 2'b11, 3'b001, 0, 0, 0, xe, xrd, xp);
      apb_xfer(32'h1008, 1, 16'h1234, 2'b11, 3'b001, 0, 0, 0, n, rd, e, q1, p1);
      checks++;
      if (q1[4*DW +: DW] !== 16'h1234) begin
         errors++; $display("FAIL pre_reset_write got %h want %h", q1[4*DW +: DW], 16'h1234);
      end
      PSEL = 1'b1; PENABLE = 1'b0; PADDR = 32'h100A; PWRITE = 1'b1; PWDATA = 16'hABCD; PSTRB = 2'b11; PPROT = 3'b001;
      @(posedge PCLK) #1;
      PENABLE = 1'b1;
      #2 PRESETn = 1'b0;
      #1;
      checks++;
      if ({PREADY, PSLVERR, PRDATA, wr_pulse, reg_q} !== '0) begin
         errors++; $display("FAIL reset_mid_access got rdy=%b err=%b rd=%h p=%b q=%h want all 0", PREADY, PSLVERR, PRDATA, wr_pulse, reg_q);
      end
      @(posedge PCLK) #1;
      PSEL = 1'b0; PENABLE = 1'b0;
      @(posedge PCLK) #1;
      PRESETn = 1'b1;
      mdl_clear();
      @(posedge PCLK) #1;
      // Access phase with no setup phase must be ignored.
      PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 32'h100A;
      seen = 1'b0;
      repeat (4) begin
         @(negedge PCLK);
         if (PREADY) seen = 1'b1;
      end
      @(posedge PCLK) #1;
      PSEL = 1'b0; PENABLE = 1'b0;
      checks++;
      if (seen !== 1'b0 || reg_q !== '0) begin
         errors++; $display("FAIL idle_penable got ready_seen=%b q=%h want 0 and 0", seen, reg_q);
      end
   endtask

   task automatic test_write_read();
      int n; logic [15:0] rd; logic e, xe; logic [15:0] xrd; logic [NR-1:0] p1, xp; logic [NR*DW-1:0] q1;
      @(posedge PCLK) #1;
      mdl_apply(32'h1004, 1, 16'hBEEF, 2'b11, 3'b001, 0, 0, 0, xe, xrd, xp);
      apb_xfer(32'h1004, 1, 16'hBEEF, 2'b11, 3'b001, 0, 0, 0, n, rd, e, q1, p1);
      checks++;
      if (n !== WS + 1 || e !== 1'b0) begin
         errors++; $display("FAIL write_resp got cycle=%0d err=%b want cycle=%0d err=0", n, e, WS + 1);
      end
      checks++;
      if (q1[2*DW +: DW] !== 16'hBEEF || p1 !== 8'b0000_0100) begin
         errors++; $display("FAIL write_update got q2=%h pulse=%b want BEEF 00000100", q1[2*DW +: DW], p1);
      end
      @(posedge PCLK) #1;
      checks++;
      if (wr_pulse !== '0) begin
         errors++; $display("FAIL pulse_width got %b want 00000000", wr_pulse);
      end
      apb_xfer(32'h1004, 0, 16'h0, 2'b00, 3'b001, 0, 0, 0, n, rd, e, q1, p1);
      checks++;
      if (rd !== 16'hBEEF || e !== 1'b0 || n !== WS + 1) begin
         errors++; $display("FAIL readback got %h err=%b cycle=%0d want BEEF 0 %0d", rd, e, n, WS + 1);
      end
   endtask

   task automatic test_partial();
      int n; logic [15:0] rd; logic e, xe; logic [15:0] xrd; logic [NR-1:0] p1, xp; logic [NR*DW-1:0] q1;
      @(posedge PCLK) #1;
      mdl_apply(32'h1004, 1, 16'h0012, 2'b01, 3'b001, 0, 0, 0, xe, xrd, xp);
      apb_xfer(32'h1004, 1, 16'h0012, 2'b01, 3'b001, 0, 0, 0, n, rd, e, q1, p1);
      checks++;
      if (q1[2*DW +: DW] !== 16'hBE12 || e !== 1'b0) begin
         errors++; $display("FAIL partial_strobe got %h err=%b want BE12 0", q1[2*DW +: DW], e);
      end
      mdl_apply(32'h100A, 1, 16'hFFFF, 2'b00, 3'b001, 0, 0, 0, xe, xrd, xp);
      apb_xfer(32'h100A, 1, 16'hFFFF, 2'b00, 3'b001, 0, 0, 0, n, rd, e, q1, p1);
      checks++;
      if (e !== 1'b0 || p1 !== 8'b0010_0000 || q1 !== mdl_flat()) begin
         errors++; $display("FAIL zero_strobe got err=%b pulse=%b q=%h want 0 00100000 %h", e, p1, q1, mdl_flat());
      end
   endtask

   task automatic test_errors();
      logic [31:0] addr [5] = '{32'h1000, 32'h1000, 32'h1010, 32'h1003, 32'h0FFE};
      logic        wr   [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      logic        xerr [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      logic [15:0] xrdv [5] = '{16'hA5B0, 16'h0, 16'h0, 16'h0, 16'h0};
      int n; logic [15:0] rd; logic e, xe; logic [15:0] xrd; logic [NR-1:0] p1, xp; logic [NR*DW-1:0] q1;
      for (int k = 0; k < 5; k++) begin
         @(posedge PCLK) #1;
         mdl_apply(addr[k], wr[k], 16'hFFFF, 2'b11, 3'b001, 0, 0, 0, xe, xrd, xp);
         apb_xfer(addr[k], wr[k], 16'hFFFF, 2'b11, 3'b001, 0, 0, 0, n, rd, e, q1, p1);
         checks++;
         if (e !== xerr[k] || rd !== xrdv[k] || p1 !== '0 || q1 !== mdl_flat()) begin
            errors++; $display("FAIL err_case%0d addr=%h got err=%b rd=%h pulse=%b want err=%b rd=%h pulse=0",
                               k, addr[k], e, rd, p1, xerr[k], xrdv[k]);
         end
      end
   endtask

   task automatic test_collision();
      int n; logic [15:0] rd; logic e, xe; logic [15:0] xrd; logic [NR-1:0] p1, xp; logic [NR*DW-1:0] q1;
      @(posedge PCLK) #1;
      mdl_apply(32'h1006, 1, 16'h2222, 2'b11, 3'b001, 1, 3'd3, 16'h1111, xe, xrd, xp);
      apb_xfer(32'h1006, 1, 16'h2222, 2'b11, 3'b001, 1, 3'd3, 16'h1111, n, rd, e, q1, p1);
      checks++;
      if (q1[3*DW +: DW] !== 16'h2222 || p1 !== 8'b0000_1000) begin
         errors++; $display("FAIL collide_same got q3=%h pulse=%b want 2222 00001000", q1[3*DW +: DW], p1);
      end
      @(posedge PCLK) #1;
      mdl_apply(32'h1006, 1, 16'h2222, 2'b11, 3'b001, 1, 3'd4, 16'h1111, xe, xrd, xp);
      apb_xfer(32'h1006, 1, 16'h2222, 2'b11, 3'b001, 1, 3'd4, 16'h1111, n, rd, e, q1, p1);
      checks++;
      if (q1[3*DW +: DW] !== 16'h2222 || q1[4*DW +: DW] !== 16'h1111) begin
         errors++; $display("FAIL collide_diff got q3=%h q4=%h want 2222 1111", q1[3*DW +: DW], q1[4*DW +: DW]);
      end
      @(posedge PCLK) #1;
      mdl_apply(32'h1008, 0, 16'h0, 2'b00, 3'b001, 1, 3'd4, 16'h5555, xe, xrd, xp);
      apb_xfer(32'h1008, 0, 16'h0, 2'b00, 3'b001, 1, 3'd4, 16'h5555, n, rd, e, q1, p1);
      checks++;
      if (rd !== 16'h1111 || q1[4*DW +: DW] !== 16'h5555) begin
         errors++; $display("FAIL read_vs_hw got rd=%h q4=%h want 1111 5555", rd, q1[4*DW +: DW]);
      end
   endtask

   task automatic test_hw_port();
      int n; logic [15:0] rd; logic e; logic [NR-1:0] p1; logic [NR*DW-1:0] q1;
      @(posedge PCLK) #1;
      hw_we = 1'b1; hw_idx = 3'd0; hw_wdata = 16'hFFFF;
      @(posedge PCLK) #1;
      hw_idx = 3'd7; hw_wdata = 16'h7777;
      @(posedge PCLK) #1;
      hw_we = 1'b0;
      mdl[7] = 16'h7777;
      checks++;
      if (reg_q[0 +: DW] !== 16'h0 || reg_q[7*DW +: DW] !== 16'h7777 || wr_pulse !== '0) begin
         errors++; $display("FAIL hw_write got q0=%h q7=%h pulse=%b want 0000 7777 0", reg_q[0 +: DW], reg_q[7*DW +: DW], wr_pulse);
      end
      apb_xfer(32'h1000, 0, 16'h0, 2'b00, 3'b001, 0, 0, 0, n, rd, e, q1, p1);
      checks++;
      if (rd !== IDV || e !== 1'b0) begin
         errors++; $display("FAIL id_after_hw got %h err=%b want %h 0", rd, e, IDV);
      end
   endtask

   task automatic test_prot();
      int n; logic [15:0] rd; logic e, xe; logic [15:0] xrd; logic [NR-1:0] p1, xp; logic [NR*DW-1:0] q1;
      logic [2:0] prots [3] = '{3'b000, 3'b001, 3'b000};
      logic       wrs   [3] = '{1'b1, 1'b1, 1'b0};
      for (int k = 0; k < 3; k++) begin
         @(posedge PCLK) #1;
         mdl_apply(32'h1004, wrs[k], 16'h0F0F + 16'(k), 2'b11, prots[k], 0, 0, 0, xe, xrd, xp);
         apb_xfer(32'h1004, wrs[k], 16'h0F0F + 16'(k), 2'b11, prots[k], 0, 0, 0, n, rd, e, q1, p1);
         checks++;
         if (e !== xe || rd !== xrd || p1 !== xp || q1 !== mdl_flat()) begin
            errors++; $display("FAIL prot%0d got err=%b rd=%h pulse=%b q2=%h want err=%b rd=%h pulse=%b q2=%h",
                               k, e, rd, p1, q1[2*DW +: DW], xe, xrd, xp, mdl[2]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int n1, n2; logic [15:0] rd; logic e1, e2, xe; logic [15:0] xrd; logic [NR-1:0] p1, xp; logic [NR*DW-1:0] q1;
      @(posedge PCLK) #1;
      mdl_apply(32'h100C, 1, 16'hC0DE, 2'b11, 3'b001, 0, 0, 0, xe, xrd, xp);
      apb_xfer(32'h100C, 1, 16'hC0DE, 2'b11, 3'b001, 0, 0, 0, n1, rd, e1, q1, p1);
      mdl_apply(32'h100C, 0, 16'h0, 2'b00, 3'b001, 0, 0, 0, xe, xrd, xp);
      apb_xfer(32'h100C, 0, 16'h0, 2'b00, 3'b001, 0, 0, 0, n2, rd, e2, q1, p1);
      checks++;
      if (n1 !== WS + 1 || n2 !== WS + 1 || e1 !== 1'b0 || e2 !== 1'b0 || rd !== 16'hC0DE) begin
         errors++; $display("FAIL back_to_back got c1=%0d c2=%0d e=%b%b rd=%h want %0d %0d 00 C0DE", n1, n2, e1, e2, rd, WS + 1, WS + 1);
      end
   endtask

   task automatic test_random();
      int n; logic [15:0] rd; logic e, xe; logic [15:0] xrd; logic [NR-1:0] p1, xp; logic [NR*DW-1:0] q1;
      logic [31:0] a; logic w, hen; logic [15:0] d, hd; logic [1:0] s; logic [2:0] pr, hi;
      @(posedge PCLK) #1;
      for (int k = 0; k < 80; k++) begin
         a   = BASE - 32'd4 + 32'($urandom_range(0, 2 * NR + 7));
         w   = 1'($urandom);
         d   = 16'($urandom);
         s   = 2'($urandom);
         pr  = 3'($urandom);
         hen = ($urandom_range(0, 3) == 0);
         hi  = 3'($urandom);
         hd  = 16'($urandom);
         mdl_apply(a, w, d, s, pr, hen, hi, hd, xe, xrd, xp);
         apb_xfer(a, w, d, s, pr, hen, hi, hd, n, rd, e, q1, p1);
         checks++;
         if (n !== WS + 1 || e !== xe || rd !== xrd || p1 !== xp || q1 !== mdl_flat()) begin
            errors++; $display("FAIL random%0d a=%h w=%b got c=%0d e=%b rd=%h p=%b q=%h want c=%0d e=%b rd=%h p=%b q=%h",
                               k, a, w, n, e, rd, p1, q1, WS + 1, xe, xrd, xp, mdl_flat());
         end
         if ($urandom_range(0, 1) == 0) @(posedge PCLK) #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got no finish within time limit want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_write_read();
      test_partial();
      test_errors();
      test_collision();
      test_hw_port();
      test_prot();
      test_back_to_back();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
